// File: rtl/rx_sel_pipe_if.sv
// rtl/rx_sel_pipe_if.sv - valid/ready operand bus for rx_sel_pipe
//
// Purpose: bundles the input beat (rx/sel/dbl/inv) and the output beat (ry)
// of the operand selector together with their valid/ready handshakes.
// Signals:
//   in_valid, in_ready        input beat handshake
//   sel[SW-1:0], dbl, inv     operand select and transform controls
//   rx[N*M-1:0]               concatenated source operands
//   out_valid, out_ready      output beat handshake
//   ry[N:0]                   selected, transformed operand
// Modports: slave = the selector itself, master = the environment driving it.
interface rx_sel_pipe_if #(
  parameter int N  = 1 << 16,
  parameter int M  = 3,
  parameter int SW = 2
) ();
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   sel;
  logic            dbl;
  logic            inv;
  logic [N*M-1:0]  rx;
  logic            out_valid;
  logic            out_ready;
  logic [N:0]      ry;

  modport slave (
    input  in_valid, sel, dbl, inv, rx, out_ready,
    output in_ready, out_valid, ry
  );

  modport master (
    output in_valid, sel, dbl, inv, rx, out_ready,
    input  in_ready, out_valid, ry
  );
endinterface

// File: rtl/rx_sel_pipe.sv
// rtl/rx_sel_pipe.sv - registered operand selector with 2-entry skid buffer
//
// Purpose: each accepted beat selects zero or one of M operands, optionally
// doubles and/or inverts it (N+1 bits), and delivers it through a valid/ready
// stage that sustains one beat per cycle under back-pressure.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      rx_sel_pipe_if.slave (in_valid/in_ready/sel/dbl/inv/rx,
//            out_valid/out_ready/ry)
//   clr_err  synchronous clear of err
//   err      sticky flag: an accepted beat carried sel > M
module rx_sel_pipe #(
  parameter int N  = 1 << 16,
  parameter int M  = 3,
  parameter int SW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rx_sel_pipe_if.slave       bus,
  input  logic               clr_err,
  output logic               err
);

  // The select field must be able to encode zero plus every operand.
  if (M < 1 || (1 << SW) < M + 1) begin : g_param_chk
    $error("rx_sel_pipe: need M >= 1 and 2**SW >= M+1");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [N:0]  main_q;   // entry currently presented on ry
  logic [N:0]  skid_q;   // second entry, only valid in S_TWO
  logic        err_q;

  logic        in_ready_w, out_valid_w;
  logic        accept, deliver, illegal;
  logic        load_main_in, load_main_skid, load_skid;
  logic [N:0]  xform;

  // Handshake flags decode the state register only, so in_ready has no
  // combinational dependence on out_ready.
  assign in_ready_w    = (state_q != S_TWO);
  assign out_valid_w   = (state_q != S_EMPTY);
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.ry        = main_q;
  assign err           = err_q;

  assign accept  = bus.in_valid && in_ready_w;
  assign deliver = out_valid_w && bus.out_ready;
  assign illegal = (32'(bus.sel) > M);

  // Input-side transform; the result is registered before reaching ry.
  always_comb begin
    xform = '0;
    for (int j = 0; j < M; j++) begin
      if (bus.sel == SW'(j + 1)) xform = {1'b0, bus.rx[j*N +: N]};
    end
    // Bit N is still zero here, so the shift never loses a bit.
    if (bus.dbl) xform = {xform[N-1:0], 1'b0};
    if (bus.inv) xform = ~xform;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d      = S_ONE;
          load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = S_TWO;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (deliver) begin
          state_d        = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main_in)        main_q <= xform;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= xform;
      // A new illegal acceptance takes priority over a same-cycle clear.
      if (accept && illegal)   err_q  <= 1'b1;
      else if (clr_err)        err_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_sel_pipe.sv
// tb/tb_rx_sel_pipe.sv - self-checking bench for rx_sel_pipe
//
// Purpose: directed vectors (reset, select sweep, transform, back-pressure,
// illegal select) plus a randomised scoreboard run against two instances:
// u_dut3 (N=8, M=3, SW=2) and u_dut2 (N=8, M=2, SW=2).
// Ports: none (top-level bench).
module tb_rx_sel_pipe;

  logic clk;
  logic rst_n;
  logic clr_err3, clr_err2;
  logic err3, err2;

  int tests_run;
  int tests_failed;

  rx_sel_pipe_if #(.N(8), .M(3), .SW(2)) if3 ();
  rx_sel_pipe_if #(.N(8), .M(2), .SW(2)) if2 ();

  rx_sel_pipe #(.N(8), .M(3), .SW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .clr_err(clr_err3), .err(err3)
  );
  rx_sel_pipe #(.N(8), .M(2), .SW(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .clr_err(clr_err2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model(input logic [23:0] rx, input logic [1:0] s,
                                       input logic d, input logic i, input int m);
    logic [8:0] v;
    v = 9'h000;
    if (s >= 2'd1 && int'(s) <= m) v = {1'b0, rx[(int'(s) - 1) * 8 +: 8]};
    if (d) v = v << 1;
    if (i) v = ~v;
    return v;
  endfunction

  task automatic drain3();
    if3.in_valid  = 1'b0;
    if3.out_ready = 1'b1;
    repeat (3) step();
  endtask

  logic [8:0] q[$];
  logic [8:0] sweep_exp [4];
  logic [1:0] bp_sel [5];
  logic [8:0] bp_exp [5];
  logic [8:0] held;
  int         bi, bo;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clr_err3     = 1'b0;
    clr_err2     = 1'b0;
    if3.in_valid = 1'b0; if3.sel = '0; if3.dbl = 1'b0; if3.inv = 1'b0;
    if3.rx = 24'hC35A01; if3.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.sel = '0; if2.dbl = 1'b0; if2.inv = 1'b0;
    if2.rx = 16'h5A01;   if2.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_ry", 32'(if3.ry), 32'h0);
    check("rst_out_valid", 32'(if3.out_valid), 32'h0);
    check("rst_err", 32'(err3), 32'h0);
    check("rst_in_ready", 32'(if3.in_ready), 32'h1);
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset while holding two beats
    if3.out_ready = 1'b0;
    if3.in_valid  = 1'b1;
    if3.sel = 2'd2; step();
    if3.sel = 2'd3; step();
    if3.in_valid = 1'b0;
    check("pre_rst_in_ready_two", 32'(if3.in_ready), 32'h0);
    check("pre_rst_out_valid", 32'(if3.out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ry", 32'(if3.ry), 32'h0);
    check("async_rst_out_valid", 32'(if3.out_valid), 32'h0);
    check("async_rst_err", 32'(err3), 32'h0);
    check("async_rst_in_ready", 32'(if3.in_ready), 32'h1);
    step();
    rst_n = 1'b1;
    if3.out_ready = 1'b1;
    if3.in_valid = 1'b1; if3.sel = 2'd1;
    step();
    if3.in_valid = 1'b0;
    check("post_rst_first_beat", 32'(if3.ry), 32'h001);
    check("post_rst_first_valid", 32'(if3.out_valid), 32'h1);
    step();
    check("post_rst_no_stale", 32'(if3.out_valid), 32'h0);

    // Select sweep, one beat per cycle
    sweep_exp[0] = 9'h000; sweep_exp[1] = 9'h001;
    sweep_exp[2] = 9'h05A; sweep_exp[3] = 9'h0C3;
    for (int k = 0; k < 4; k++) begin
      if3.in_valid = 1'b1;
      if3.sel = 2'(k);
      step();
      check($sformatf("sweep_ry_sel%0d", k), 32'(if3.ry), 32'(sweep_exp[k]));
      check($sformatf("sweep_valid_sel%0d", k), 32'(if3.out_valid), 32'h1);
    end
    drain3();

    // Transform
    if3.in_valid = 1'b1; if3.sel = 2'd3;
    if3.dbl = 1'b1; if3.inv = 1'b0; step();
    check("xform_dbl", 32'(if3.ry), 32'h186);
    if3.dbl = 1'b0; if3.inv = 1'b1; step();
    check("xform_inv", 32'(if3.ry), 32'h13C);
    if3.dbl = 1'b1; if3.inv = 1'b1; step();
    check("xform_dbl_inv", 32'(if3.ry), 32'h079);
    if3.dbl = 1'b0; if3.inv = 1'b0;
    drain3();

    // Back-pressure: out_ready low for 3 cycles
    bp_sel[0] = 2'd1; bp_sel[1] = 2'd2; bp_sel[2] = 2'd3; bp_sel[3] = 2'd1; bp_sel[4] = 2'd2;
    bp_exp[0] = 9'h001; bp_exp[1] = 9'h05A; bp_exp[2] = 9'h0C3; bp_exp[3] = 9'h001; bp_exp[4] = 9'h05A;
    bi = 0; bo = 0; held = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if3.out_ready = (cyc >= 3);
      if3.in_valid  = (bi < 5);
      if3.sel       = bp_sel[(bi < 5) ? bi : 4];
      if (cyc == 1) held = if3.ry;
      if (cyc == 2) begin
        check("bp_in_ready_after_2", 32'(if3.in_ready), 32'h0);
        check("bp_ry_held", 32'(if3.ry), 32'(held));
      end
      if (cyc == 3) check("bp_in_ready_until_deliver", 32'(if3.in_ready), 32'h0);
      if (if3.out_valid && if3.out_ready) begin
        if (bo < 5) check($sformatf("bp_order_%0d", bo), 32'(if3.ry), 32'(bp_exp[bo]));
        else check("bp_extra_beat", 32'(bo), 32'd4);
        bo++;
      end
      if (if3.in_valid && if3.in_ready) bi++;
      step();
    end
    check("bp_delivered_count", 32'(bo), 32'd5);
    drain3();

    // Illegal select on the M=2 instance
    if2.in_valid = 1'b1; if2.sel = 2'd3; if2.inv = 1'b0;
    step();
    if2.in_valid = 1'b0;
    check("illegal_ry_zero", 32'(if2.ry), 32'h000);
    check("illegal_err_set", 32'(err2), 32'h1);
    step();
    check("illegal_err_sticky", 32'(err2), 32'h1);
    clr_err2 = 1'b1; step(); clr_err2 = 1'b0;
    check("illegal_err_cleared", 32'(err2), 32'h0);
    clr_err2 = 1'b1; if2.in_valid = 1'b1; if2.sel = 2'd3; if2.inv = 1'b1;
    step();
    clr_err2 = 1'b0; if2.in_valid = 1'b0; if2.inv = 1'b0;
    check("illegal_set_wins", 32'(err2), 32'h1);
    check("illegal_inv_ry", 32'(if2.ry), 32'h1FF);
    if2.in_valid = 1'b1; if2.sel = 2'd2;
    step();
    if2.in_valid = 1'b0;
    check("m2_legal_sel2", 32'(if2.ry), 32'h05A);

    // Random stress with scoreboard
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if3.in_valid  = 1'($urandom);
      if3.out_ready = 1'($urandom);
      if3.sel       = 2'($urandom_range(0, 3));
      if3.dbl       = 1'($urandom);
      if3.inv       = 1'($urandom);
      if3.rx        = 24'($urandom);
      check("rnd_in_ready_two_only", 32'(if3.in_ready), 32'(q.size() < 2));
      check("rnd_out_valid", 32'(if3.out_valid), 32'(q.size() != 0));
      if (if3.out_valid && if3.out_ready) begin
        if (q.size() == 0) check("rnd_dup_beat", 32'(if3.ry), 32'h3FF);
        else check("rnd_ry", 32'(if3.ry), 32'(q.pop_front()));
      end
      if (if3.in_valid && if3.in_ready)
        q.push_back(model(if3.rx, if3.sel, if3.dbl, if3.inv, 3));
      step();
    end
    if3.in_valid = 1'b0;
    if3.out_ready = 1'b1;
    for (int k = 0; k < 4 && q.size() != 0; k++) begin
      if (if3.out_valid) check("rnd_drain_ry", 32'(if3.ry), 32'(q.pop_front()));
      step();
    end
    check("rnd_no_loss", 32'(q.size()), 32'd0);
    check("rnd_final_empty", 32'(if3.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rx_sel_pipe.md
Name: rx_sel_pipe

Overview:
- Registered, parametrised operand selector for the pipelined carry-save modular-multiplier datapath.
- Each cycle it picks zero or one of M source operands, optionally doubled or inverted, and delivers it through a valid/ready elastic stage.
- A 2-entry skid buffer gives full throughput under back-pressure. It sits between the digit-decode stage and the carry-save adder stage.

Parameters:
N, 1<<16, operand width in bits
M, 3, number of source operands (M >= 1)
SW, 2, select width; 2^SW >= M+1 is a hard requirement (elaboration error otherwise)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
sel  in  SW  0 = zero, k in 1..M = operand k-1, k > M = illegal
dbl  in  1  output operand shifted left by 1 (x2)
inv  in  1  output bitwise complement of the (possibly doubled) value, N+1 bits
rx  in  N*M  concatenated sources; operand j = rx[j*N +: N]
clr_err  in  1  synchronous clear of err
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
ry  out  N+1  selected, transformed operand
err  out  1  sticky: an accepted beat carried illegal sel

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid = 0, ry = 0, err = 0, in_ready = 1.
  - Both skid entries are empty.
  - Reset mid-transfer drops all buffered beats; no partial output.
- Transform for an accepted beat:
  - v = (sel==0 || sel>M) ? 0 : {1'b0, operand[sel-1]}.
  - If dbl, v = v << 1, width N+1, no truncation.
  - If inv, v = ~v over N+1 bits.
  - The transform is computed on the input side and stored; no combinational path from rx to ry.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A beat is delivered when out_valid && out_ready.
  - rx, sel, dbl and inv are sampled only at acceptance.
  - ry and out_valid are stable while out_valid && !out_ready.
- Latency: an accepted beat is visible on ry/out_valid the following cycle when the main register is empty or draining that same cycle.
- Skid buffer states:
  - EMPTY: out_valid = 0, in_ready = 1. Accept → ONE.
  - ONE: out_valid = 1, in_ready = 1.
    - Accept with no deliver → TWO.
    - Accept with deliver → ONE, new beat moves to the main register.
    - Deliver only → EMPTY.
    - Neither → ONE.
  - TWO: out_valid = 1, in_ready = 0 (registered, not derived from out_ready).
    - Deliver → ONE, skid entry moves to the main register.
    - No deliver → stays TWO.
- Ordering is strict FIFO. Throughput is 1 beat/cycle whenever out_ready is held high.
- No beat is duplicated or lost under any in_valid/out_ready pattern.
- err:
  - Set on the cycle after acceptance of a beat with sel > M.
  - That beat is still delivered, as zero (after dbl/inv).
  - clr_err clears err. If clr_err and a new illegal acceptance occur in the same cycle, set wins.
- in_ready depends only on registered state (no out_ready → in_ready combinational path).

Test Plan:
1. Reset:
   - Stimulus: hold rst_n low mid-stream with out_valid=1, in state TWO.
   - Required: ry=0, out_valid=0, err=0, in_ready=1 immediately (asynchronous). The post-reset beat is the first delivered.
2. Select sweep:
   - Stimulus: N=8, M=3, SW=2, rx={8'hC3, 8'h5A, 8'h01}, sel=0..3, dbl=inv=0, out_ready=1.
   - Required: ry = 9'h000, 9'h001, 9'h05A, 9'h0C3 on consecutive cycles, each 1 cycle after acceptance.
3. Transform:
   - Stimulus: sel=3 with rx operand 2 = 8'hC3.
   - Required, dbl=1: ry=9'h186.
   - Required, inv=1, dbl=0: ry=9'h13C.
   - Required, dbl=1 and inv=1: ry=9'h079.
4. Back-pressure:
   - Stimulus: stream 5 beats (sel=1,2,3,1,2) with out_ready=0 for 3 cycles, then 1.
   - Required: in_ready falls after 2 accepts, stays 0 until the first deliver. Output order is exactly 1,2,3,1,2 values; ry is held stable while stalled.
5. Illegal select:
   - Stimulus: N=8, M=2, SW=2, sel=3, inv=0.
   - Required: ry=0, err=1 the cycle after acceptance, err stays 1.
   - Then: clr_err pulse → err=0. clr_err together with another sel=3 acceptance → err remains 1.
6. Random stress:
   - Stimulus: 10k cycles of random in_valid/out_ready/sel/dbl/inv.
   - Required: the scoreboard matches every beat in order, no loss or duplication, and in_ready=0 only in state TWO.
